// File: rtl/i2f_pipe.sv
`default_nettype none
// ============================================================================
// Module : i2f_pipe
// Brief  : 3-stage valid/ready integer-to-binary32 converter, all 4 rounding modes
// Rev    : 1.0  initial release
// ============================================================================
module i2f_pipe #(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] d,
  input  logic          sgn,
  input  logic [1:0]    rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   a,
  output logic          p_lost
);
  localparam int            KW      = $clog2(IW);
  localparam logic [KW-1:0] MSB_IDX = KW'(IW - 1);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RTZ = 2'b11;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: sign and magnitude; -d of the most-negative value wraps to 2^(IW-1)
  logic          w_s;
  logic [IW-1:0] w_mag;
  assign w_s   = sgn & d[IW-1];
  assign w_mag = w_s ? (-d) : d;

  logic          r_v1, r_s1;
  logic [IW-1:0] r_m1;
  logic [1:0]    r_rm1;

  // Stage 2: leading-one search and left normalisation
  logic [KW-1:0] w_k;
  logic [IW-1:0] w_norm;
  logic          w_zero;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < IW; i++) begin
      if (r_m1[i]) w_k = KW'(i);
    end
  end

  assign w_norm = r_m1 << (MSB_IDX - w_k);
  assign w_zero = ~|r_m1;

  logic          r_v2, r_z2, r_s2;
  logic [KW-1:0] r_k2;
  logic [IW-1:0] r_n2;
  logic [1:0]    r_rm2;

  // Stage 3: zero-padding below the operand keeps guard/sticky at 0 when k <= 23
  logic [IW+24:0] w_ext;
  logic [23:0]    w_sig;
  logic           w_guard, w_sticky, w_inc;
  logic [24:0]    w_sum;
  logic [22:0]    w_frac;
  logic [7:0]     w_exp;
  logic [31:0]    w_a;
  logic           w_p;

  assign w_ext    = {r_n2, 25'd0};
  assign w_sig    = w_ext[IW+24 -: 24];
  assign w_guard  = w_ext[IW];
  assign w_sticky = |w_ext[IW-1:0];

  always_comb begin
    w_inc = 1'b0;
    case (r_rm2)
      RM_RNE:  w_inc = w_guard & (w_sticky | w_sig[0]);
      RM_RDN:  w_inc = r_s2 & (w_guard | w_sticky);
      RM_RUP:  w_inc = ~r_s2 & (w_guard | w_sticky);
      RM_RTZ:  w_inc = 1'b0;
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out means the significand became 2^24: renormalise by one place
  assign w_sum  = {1'b0, w_sig} + 25'(w_inc);
  assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
  assign w_exp  = 8'd127 + 8'(r_k2) + 8'(w_sum[24]);
  assign w_a    = r_z2 ? 32'd0 : {r_s2, w_exp, w_frac};
  assign w_p    = ~r_z2 & (w_guard | w_sticky);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_v1      <= 1'b0;
      r_s1      <= 1'b0;
      r_m1      <= '0;
      r_rm1     <= '0;
      r_v2      <= 1'b0;
      r_z2      <= 1'b0;
      r_s2      <= 1'b0;
      r_k2      <= '0;
      r_n2      <= '0;
      r_rm2     <= '0;
      out_valid <= 1'b0;
      a         <= '0;
      p_lost    <= 1'b0;
    end else if (adv) begin
      r_v1      <= in_valid;
      r_s1      <= w_s;
      r_m1      <= w_mag;
      r_rm1     <= rm;
      r_v2      <= r_v1;
      r_z2      <= w_zero;
      r_s2      <= r_s1;
      r_k2      <= w_k;
      r_n2      <= w_norm;
      r_rm2     <= r_rm1;
      out_valid <= r_v2;
      a         <= w_a;
      p_lost    <= w_p;
    end
  end

endmodule
`default_nettype wire

// File: doc/i2f_pipe.md
Name: i2f_pipe

Overview:
- Pipelined, parametrised integer-to-single-precision-float converter for the FPU datapath.
- Next generation of the combinational i2f converter, with:
  - configurable input width
  - signed or unsigned operand mode per transaction
  - all four IEEE rounding modes, using the FPU `rm` encoding
  - valid/ready handshaking with backpressure across a 3-stage pipeline.
- Accepts one conversion per cycle. Delivers the result with an inexact (`p_lost`) flag.

Parameters:
- IW, 32, integer operand width in bits; legal range 8..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present on `d`/`sgn`/`rm`.
- in_ready  output  1  converter accepts the operand this cycle.
- d  input  IW  integer operand.
- sgn  input  1  1 = `d` is two's-complement signed; 0 = unsigned.
- rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- a  output  32  IEEE-754 single-precision result.
- p_lost  output  1  1 = the result is inexact (precision lost).

Behaviour:
- Reset (`clrn` = 0, asynchronous): all stage valid bits clear; `out_valid` = 0; `a` = 0; `p_lost` = 0. Datapath registers clear to 0.
- Reset asserted mid-operation discards all in-flight transactions; no partial result ever appears.
- Pipeline advance: `adv = ~out_valid | out_ready`.
  - `in_ready = adv`.
  - When `adv` = 1, every stage shifts forward one position and stage 1 captures `in_valid` together with its operand.
  - When `adv` = 0, all stages hold: operands, `rm`, sign and valid bits.
  - A transfer occurs when valid and ready are both 1. Result and operand handshakes in the same cycle are legal.
- Latency: 3 cycles from input acceptance to `out_valid`, when not stalled. Throughput: 1 per cycle. Transaction order is preserved.
- Stage 1 (magnitude):
  - `s = sgn & d[IW-1]`.
  - `M = s ? -d : d`, held as IW-bit unsigned.
  - The most-negative signed value gives `M = 2^(IW-1)` with no overflow.
  - Register `s`, `M` and `rm`.
- Stage 2 (normalize):
  - `k` = index of the leading 1 of `M`. A priority encoder is acceptable; it need not be a tree.
  - Left-shift `M` so that bit `k` lands at the MSB.
  - Register: zero flag (`M == 0`), `k`, shifted mantissa, `s`, `rm`.
- Stage 3 (round and pack):
  - Significand = leading 1 plus the next 23 bits.
  - If `k > 23`: guard = next bit below the significand; sticky = OR of all remaining lower bits. Otherwise guard = sticky = 0.
  - Increment rule:
    - RNE: `guard & (sticky | lsb)`.
    - Toward -inf: `s & (guard | sticky)`.
    - Toward +inf: `~s & (guard | sticky)`.
    - Toward zero: never.
  - Mantissa carry-out (significand rounds to 2^24): exponent + 1, fraction = 0.
  - Exponent = 127 + `k` (+1 on carry). It never overflows for IW ≤ 64.
  - `a = {s, exp[7:0], frac[22:0]}`.
  - `p_lost = guard | sticky`.
  - `M == 0`: `a` = 0x00000000 (+0, for every `rm`), `p_lost` = 0.
- Outputs `a`/`p_lost` are registered. They hold stable while `out_valid & ~out_ready`.

Test Plan:
- IW=32, sgn=1, rm=00, stream with in_valid=1 and out_ready=1; outputs begin 3 cycles after the first acceptance, one per cycle:
  - 0x1fffffff -> 0x4E000000, p_lost=1
  - 0x00000001 -> 0x3F800000, 0
  - 0x7fffff80 -> 0x4EFFFFFF, 0
  - 0x7fffffc0 -> 0x4F000000, 1
  - 0x80000000 -> 0xCF000000, 0
  - 0x80000040 -> 0xCF000000, 1
  - 0xffffffff -> 0xBF800000, 0
  - 0x00000000 -> 0x00000000, 0
- Rounding modes on 0x80000040, sgn=1:
  - rm=11 -> 0xCEFFFFFF
  - rm=01 -> 0xCF000000
  - rm=10 -> 0xCEFFFFFF
  - p_lost=1 in all cases.
- Unsigned mode, sgn=0:
  - 0xffffffff, rm=00 -> 0x4F800000, p_lost=1
  - 0xffffffff, rm=11 -> 0x4F7FFFFF
  - 0x80000000 -> 0x4F000000, p_lost=0
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 continuously. Required: in_ready drops once out_valid=1; `a` stays stable; no transaction is lost or duplicated.
  - Release out_ready: results emerge in order.
- Reset mid-stream: drop clrn asynchronously with 3 transactions in flight. Required: out_valid=0, a=0 and p_lost=0 immediately; nothing is emitted after release until new inputs are accepted.
- IW=8 instance:
  - d=0x80, sgn=1 -> 0xC3000000
  - d=0xff, sgn=0 -> 0x437F0000, p_lost=0
